// File: rtl/noc_link_rx_pkg.sv
// Shared NoC definitions for the link receiver: default field widths,
// the packed flit layout and sizing helpers.
package noc_link_rx_pkg;

  localparam int NOC_FLIT_WIDTH  = 128;
  localparam int NOC_TID_WIDTH   = 2;
  localparam int NOC_TDEST_WIDTH = 4;
  localparam int NOC_DEST_WIDTH  = NOC_TID_WIDTH + NOC_TDEST_WIDTH;

  // Flit as carried on the link. The receive buffer stores entries with
  // exactly this field order: {data, dest, is_tail}, is_tail in bit 0.
  typedef struct packed {
    logic [NOC_FLIT_WIDTH-1:0] data;
    logic [NOC_DEST_WIDTH-1:0] dest;
    logic                      is_tail;
  } flit_t;

  // Width of one stored entry for a given flit/dest width.
  function automatic int flit_entry_width(input int flit_w, input int dest_w);
    return flit_w + dest_w + 1;
  endfunction

  // Pointer width for a circular buffer; a single-slot buffer still
  // needs one pointer bit so the port is never zero-width.
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/noc_link_rx_fifo.sv
// Circular receive buffer: storage, read/write pointers and fill count.
// Pointers wrap modulo DEPTH so non-power-of-two depths work. A push into a
// full buffer is only taken when a pop happens in the same cycle.
module noc_link_rx_fifo
  import noc_link_rx_pkg::*;
#(
  parameter int ENTRY_WIDTH = 8,
  parameter int DEPTH       = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic                         pop,
  input  logic [ENTRY_WIDTH-1:0]       wdata,
  output logic [ENTRY_WIDTH-1:0]       rdata,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int PTR_W = ptr_width(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [ENTRY_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic [CNT_W-1:0]       count_r;
  logic                   do_push;
  logic                   do_pop;

  // Advance a pointer, wrapping from the last slot back to slot 0.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  assign full    = (count_r == FULL_CNT);
  assign empty   = (count_r == '0);
  assign do_pop  = pop & ~empty;
  // When full, the slot being freed by the pop is the write slot.
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr];
  assign count   = count_r;

  // Storage write; data only, never reset.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Write pointer advances on every accepted push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
    end else if (do_push) begin
      wr_ptr <= ptr_inc(wr_ptr);
    end else begin
      wr_ptr <= wr_ptr;
    end
  end

  // Read pointer advances on every pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
    end else if (do_pop) begin
      rd_ptr <= ptr_inc(rd_ptr);
    end else begin
      rd_ptr <= rd_ptr;
    end
  end

  // Fill count: +1 push, -1 pop, unchanged when both or neither.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= '0;
    end else begin
      case ({do_push, do_pop})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/noc_link_rx.sv
// NoC link receiver: buffers credit-flow-controlled flits from an upstream
// router and presents them as an AXI-Stream master. Returns one credit per
// popped flit, flags sticky overflow on a flit sent into a full buffer, and
// counts delivered packets (tail flits popped).
module noc_link_rx
  import noc_link_rx_pkg::*;
#(
  parameter int FLIT_WIDTH        = NOC_FLIT_WIDTH,
  parameter int TID_WIDTH         = NOC_TID_WIDTH,
  parameter int TDEST_WIDTH       = NOC_TDEST_WIDTH,
  parameter int DEST_WIDTH        = TID_WIDTH + TDEST_WIDTH,
  parameter int FLIT_BUFFER_DEPTH = 4
) (
  input  logic                                 clk_noc,
  input  logic                                 rst_n,
  input  logic [FLIT_WIDTH-1:0]                data_in,
  input  logic [DEST_WIDTH-1:0]                dest_in,
  input  logic                                 is_tail_in,
  input  logic                                 send_in,
  output logic                                 credit_out,
  output logic                                 axis_out_tvalid,
  input  logic                                 axis_out_tready,
  output logic [FLIT_WIDTH-1:0]                axis_out_tdata,
  output logic                                 axis_out_tlast,
  output logic [TID_WIDTH-1:0]                 axis_out_tid,
  output logic [TDEST_WIDTH-1:0]               axis_out_tdest,
  output logic [$clog2(FLIT_BUFFER_DEPTH+1)-1:0] occupancy,
  output logic                                 overflow_err,
  output logic [15:0]                          pkt_count
);

  localparam int ENTRY_W = flit_entry_width(FLIT_WIDTH, DEST_WIDTH);

  logic [ENTRY_W-1:0]    wr_entry;
  logic [ENTRY_W-1:0]    rd_entry;
  logic [DEST_WIDTH-1:0] head_dest;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  pop;
  logic                  push;
  logic                  credit_r;
  logic                  overflow_r;
  logic [15:0]           pkt_count_r;

  // Entry layout matches flit_t: {data, dest, is_tail}.
  assign wr_entry = {data_in, dest_in, is_tail_in};

  assign pop  = axis_out_tvalid & axis_out_tready;
  assign push = send_in & (~fifo_full | pop);

  noc_link_rx_fifo #(
    .ENTRY_WIDTH (ENTRY_W),
    .DEPTH       (FLIT_BUFFER_DEPTH)
  ) u_fifo (
    .clk   (clk_noc),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .wdata (wr_entry),
    .rdata (rd_entry),
    .count (occupancy),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Head entry straight from storage; stable while not popped.
  assign head_dest       = rd_entry[DEST_WIDTH:1];
  assign axis_out_tvalid = ~fifo_empty;
  assign axis_out_tdata  = rd_entry[ENTRY_W-1 -: FLIT_WIDTH];
  assign axis_out_tid    = head_dest[DEST_WIDTH-1:TDEST_WIDTH];
  assign axis_out_tdest  = head_dest[TDEST_WIDTH-1:0];
  assign axis_out_tlast  = rd_entry[0];

  assign credit_out   = credit_r;
  assign overflow_err = overflow_r;
  assign pkt_count    = pkt_count_r;

  // Credit return: a one-cycle pulse the cycle after each pop.
  always_ff @(posedge clk_noc or negedge rst_n) begin
    if (!rst_n) begin
      credit_r <= 1'b0;
    end else begin
      credit_r <= pop;
    end
  end

  // Sticky overflow: a flit arrived with no free slot and no pop to make one.
  always_ff @(posedge clk_noc or negedge rst_n) begin
    if (!rst_n) begin
      overflow_r <= 1'b0;
    end else if (send_in & fifo_full & ~pop) begin
      overflow_r <= 1'b1;
    end else begin
      overflow_r <= overflow_r;
    end
  end

  // Delivered-packet counter: one per popped tail flit, wraps at 16 bits.
  always_ff @(posedge clk_noc or negedge rst_n) begin
    if (!rst_n) begin
      pkt_count_r <= 16'h0000;
    end else if (pop & axis_out_tlast) begin
      pkt_count_r <= pkt_count_r + 16'h0001;
    end else begin
      pkt_count_r <= pkt_count_r;
    end
  end

endmodule

// File: tb/tb_noc_link_rx.sv
// Self-checking bench for noc_link_rx: a depth-4 and a depth-3 instance,
// each shadowed by a queue-based model of the credit-flow link.
module tb_noc_link_rx;

  typedef struct packed {
    logic [127:0] data;
    logic [5:0]   dest;
    logic         tail;
  } flit_s;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  // depth-4 instance signals
  logic [127:0] data4 = '0;
  logic [5:0]   dest4 = '0;
  logic         tail4 = 1'b0, send4 = 1'b0, tready4 = 1'b0;
  logic         credit4, tvalid4, tlast4, ovf4;
  logic [127:0] tdata4;
  logic [1:0]   tid4;
  logic [3:0]   tdest4;
  logic [2:0]   occ4;
  logic [15:0]  pkt4;

  // depth-3 instance signals
  logic [127:0] data3 = '0;
  logic [5:0]   dest3 = '0;
  logic         tail3 = 1'b0, send3 = 1'b0, tready3 = 1'b0;
  logic         credit3, tvalid3, tlast3, ovf3;
  logic [127:0] tdata3;
  logic [1:0]   tid3;
  logic [3:0]   tdest3;
  logic [1:0]   occ3;
  logic [15:0]  pkt3;

  noc_link_rx #(.FLIT_BUFFER_DEPTH(4)) dut4 (
    .clk_noc(clk), .rst_n(rst_n), .data_in(data4), .dest_in(dest4),
    .is_tail_in(tail4), .send_in(send4), .credit_out(credit4),
    .axis_out_tvalid(tvalid4), .axis_out_tready(tready4), .axis_out_tdata(tdata4),
    .axis_out_tlast(tlast4), .axis_out_tid(tid4), .axis_out_tdest(tdest4),
    .occupancy(occ4), .overflow_err(ovf4), .pkt_count(pkt4));

  noc_link_rx #(.FLIT_BUFFER_DEPTH(3)) dut3 (
    .clk_noc(clk), .rst_n(rst_n), .data_in(data3), .dest_in(dest3),
    .is_tail_in(tail3), .send_in(send3), .credit_out(credit3),
    .axis_out_tvalid(tvalid3), .axis_out_tready(tready3), .axis_out_tdata(tdata3),
    .axis_out_tlast(tlast3), .axis_out_tid(tid3), .axis_out_tdest(tdest3),
    .occupancy(occ3), .overflow_err(ovf3), .pkt_count(pkt3));

  // Reference model state
  flit_s       q4[$];
  flit_s       q3[$];
  logic        exp_credit4, exp_credit3, exp_ovf4, exp_ovf3;
  logic [15:0] exp_pkt4, exp_pkt3;

  int tests_run = 0;
  int tests_failed = 0;

  function automatic flit_s rand_flit(input logic tail);
    flit_s f;
    f.data = {$urandom, $urandom, $urandom, $urandom};
    f.dest = 6'($urandom_range(0, 63));
    f.tail = tail;
    return f;
  endfunction

  task automatic drive4(input flit_s f, input logic s);
    data4 = f.data; dest4 = f.dest; tail4 = f.tail; send4 = s;
  endtask

  task automatic drive3(input flit_s f, input logic s);
    data3 = f.data; dest3 = f.dest; tail3 = f.tail; send3 = s;
  endtask

  task automatic clear_model();
    q4.delete(); q3.delete();
    exp_credit4 = 1'b0; exp_credit3 = 1'b0;
    exp_ovf4 = 1'b0; exp_ovf3 = 1'b0;
    exp_pkt4 = 16'h0000; exp_pkt3 = 16'h0000;
  endtask

  // One clock of the link: decide from the model what the edge does, then
  // apply it. Sender sees a slot if the buffer has room or a flit leaves now.
  task automatic advance();
    logic pop4, acc4, pop3, acc3;
    flit_s f4, f3;
    pop4 = (q4.size() > 0) && tready4;
    acc4 = send4 && ((q4.size() < 4) || pop4);
    pop3 = (q3.size() > 0) && tready3;
    acc3 = send3 && ((q3.size() < 3) || pop3);
    f4 = '{data4, dest4, tail4};
    f3 = '{data3, dest3, tail3};
    @(posedge clk);
    #1;
    if (pop4) begin
      if (q4[0].tail) exp_pkt4 = exp_pkt4 + 16'h0001;
      void'(q4.pop_front());
    end
    if (acc4) q4.push_back(f4);
    if (send4 && !acc4) exp_ovf4 = 1'b1;
    exp_credit4 = pop4;
    if (pop3) begin
      if (q3[0].tail) exp_pkt3 = exp_pkt3 + 16'h0001;
      void'(q3.pop_front());
    end
    if (acc3) q3.push_back(f3);
    if (send3 && !acc3) exp_ovf3 = 1'b1;
    exp_credit3 = pop3;
  endtask

  task automatic do_reset();
    send4 = 1'b0; send3 = 1'b0; tready4 = 1'b0; tready3 = 1'b0;
    rst_n = 1'b0;
    clear_model();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #3;
    rst_n = 1'b0;
    #1;
    clear_model();
    tests_run++;
    if ({tvalid4, credit4, occ4, ovf4, pkt4} !== 22'd0) begin
      tests_failed++;
      $display("FAIL reset4: got tvalid=%b credit=%b occ=%0d ovf=%b pkt=%0d want all 0",
               tvalid4, credit4, occ4, ovf4, pkt4);
    end
    tests_run++;
    if ({tvalid3, credit3, occ3, ovf3, pkt3} !== 21'd0) begin
      tests_failed++;
      $display("FAIL reset3: got tvalid=%b credit=%b occ=%0d ovf=%b pkt=%0d want all 0",
               tvalid3, credit3, occ3, ovf3, pkt3);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int credits = 0;
    do_reset();
    tready4 = 1'b1;
    for (int k = 0; k < 8; k++) begin
      credits += int'(credit4);
      tests_run++;
      if (tvalid4 !== (q4.size() > 0)) begin
        tests_failed++;
        $display("FAIL basic_tvalid: got %b want %b", tvalid4, q4.size() > 0);
      end
      tests_run++;
      if (credit4 !== exp_credit4) begin
        tests_failed++;
        $display("FAIL basic_credit: got %b want %b", credit4, exp_credit4);
      end
      if (q4.size() > 0) begin
        tests_run++;
        if ({tdata4, tid4, tdest4, tlast4} !== {q4[0].data, q4[0].dest, q4[0].tail}) begin
          tests_failed++;
          $display("FAIL basic_head: got %h/%h/%h/%b want %h/%h/%b",
                   tdata4, tid4, tdest4, tlast4, q4[0].data, q4[0].dest, q4[0].tail);
        end
        tests_run++;
        if ({tid4, tdest4} !== 6'b10_1011) begin
          tests_failed++;
          $display("FAIL basic_tid_tdest: got tid=%b tdest=%h want tid=10 tdest=b", tid4, tdest4);
        end
      end
      if (k < 4) begin
        flit_s f;
        f = rand_flit(k == 3);
        f.dest = 6'h2B;
        drive4(f, 1'b1);
      end else begin
        send4 = 1'b0;
      end
      advance();
    end
    tests_run++;
    if (credits !== 4) begin
      tests_failed++;
      $display("FAIL basic_credit_total: got %0d want 4", credits);
    end
    tests_run++;
    if (pkt4 !== 16'd1) begin
      tests_failed++;
      $display("FAIL basic_pkt_count: got %0d want 1", pkt4);
    end
  endtask

  task automatic test_overflow();
    flit_s sent[5];
    do_reset();
    for (int i = 0; i < 5; i++) sent[i] = rand_flit(i == 3);
    for (int i = 0; i < 4; i++) begin
      drive4(sent[i], 1'b1);
      advance();
      tests_run++;
      if (credit4 !== 1'b0) begin
        tests_failed++;
        $display("FAIL ovf_fill_credit: got %b want 0", credit4);
      end
    end
    send4 = 1'b0;
    tests_run++;
    if (occ4 !== 3'd4 || tvalid4 !== 1'b1 || tdata4 !== sent[0].data) begin
      tests_failed++;
      $display("FAIL ovf_full_state: got occ=%0d tvalid=%b data=%h want 4/1/%h",
               occ4, tvalid4, tdata4, sent[0].data);
    end
    advance();
    tests_run++;
    if (tdata4 !== sent[0].data || tlast4 !== sent[0].tail || credit4 !== 1'b0) begin
      tests_failed++;
      $display("FAIL ovf_hold: got data=%h credit=%b want %h/0", tdata4, credit4, sent[0].data);
    end
    drive4(sent[4], 1'b1);
    advance();
    send4 = 1'b0;
    tests_run++;
    if (ovf4 !== 1'b1 || occ4 !== 3'd4) begin
      tests_failed++;
      $display("FAIL ovf_set: got ovf=%b occ=%0d want 1/4", ovf4, occ4);
    end
    tready4 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if ({tvalid4, tdata4, tid4, tdest4, tlast4} !== {1'b1, sent[i].data, sent[i].dest, sent[i].tail}) begin
        tests_failed++;
        $display("FAIL ovf_drain%0d: got v=%b %h want %h", i, tvalid4, tdata4, sent[i].data);
      end
      advance();
    end
    tests_run++;
    if (tvalid4 !== 1'b0 || ovf4 !== 1'b1 || occ4 !== 3'd0) begin
      tests_failed++;
      $display("FAIL ovf_after_drain: got tvalid=%b ovf=%b occ=%0d want 0/1/0", tvalid4, ovf4, occ4);
    end
  endtask

  task automatic test_full_pushpop();
    flit_s sent[5];
    do_reset();
    for (int i = 0; i < 5; i++) sent[i] = rand_flit(1'b0);
    for (int i = 0; i < 4; i++) begin
      drive4(sent[i], 1'b1);
      advance();
    end
    drive4(sent[4], 1'b1);
    tready4 = 1'b1;
    advance();
    send4 = 1'b0;
    tready4 = 1'b0;
    tests_run++;
    if (occ4 !== 3'd4 || ovf4 !== 1'b0 || credit4 !== 1'b1) begin
      tests_failed++;
      $display("FAIL pushpop_full: got occ=%0d ovf=%b credit=%b want 4/0/1", occ4, ovf4, credit4);
    end
    advance();
    tests_run++;
    if (credit4 !== 1'b0) begin
      tests_failed++;
      $display("FAIL pushpop_credit_width: got %b want 0", credit4);
    end
    tready4 = 1'b1;
    for (int i = 1; i < 5; i++) begin
      tests_run++;
      if ({tvalid4, tdata4, tid4, tdest4} !== {1'b1, sent[i].data, sent[i].dest}) begin
        tests_failed++;
        $display("FAIL pushpop_drain%0d: got v=%b %h want %h", i, tvalid4, tdata4, sent[i].data);
      end
      advance();
    end
  endtask

  task automatic test_wrap3();
    flit_s expq[$];
    int avail = 3, sent_n = 0, recv_n = 0, credits = 0, cyc = 0;
    do_reset();
    while ((recv_n < 10 || credits < 10) && cyc < 400) begin
      credits += int'(credit3);
      avail += int'(credit3);
      tests_run++;
      if (credit3 !== exp_credit3 || occ3 !== 2'(q3.size()) || tvalid3 !== (q3.size() > 0)) begin
        tests_failed++;
        $display("FAIL wrap3_state: got credit=%b occ=%0d v=%b want %b/%0d/%b",
                 credit3, occ3, tvalid3, exp_credit3, q3.size(), q3.size() > 0);
      end
      tready3 = 1'($urandom_range(0, 1));
      if (tvalid3 && tready3) begin
        tests_run++;
        if (recv_n >= expq.size() || {tdata3, tid3, tdest3, tlast3} !== expq[recv_n]) begin
          tests_failed++;
          $display("FAIL wrap3_order%0d: got %h/%h/%h/%b", recv_n, tdata3, tid3, tdest3, tlast3);
        end
        recv_n++;
      end
      if (sent_n < 10 && avail > 0) begin
        flit_s f;
        f = rand_flit(1'($urandom_range(0, 1)));
        expq.push_back(f);
        drive3(f, 1'b1);
        avail--;
        sent_n++;
      end else begin
        send3 = 1'b0;
      end
      advance();
      cyc++;
    end
    tests_run++;
    if (recv_n != 10 || credits != 10 || ovf3 !== 1'b0 || pkt3 !== exp_pkt3) begin
      tests_failed++;
      $display("FAIL wrap3_totals: got recv=%0d credits=%0d ovf=%b pkt=%0d want 10/10/0/%0d",
               recv_n, credits, ovf3, pkt3, exp_pkt3);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      tests_run++;
      if (tvalid4 !== (q4.size() > 0) || occ4 !== 3'(q4.size())) begin
        tests_failed++;
        $display("FAIL rand_occ c%0d: got v=%b occ=%0d want %b/%0d", c, tvalid4, occ4, q4.size() > 0, q4.size());
      end
      if (q4.size() > 0) begin
        tests_run++;
        if ({tdata4, tid4, tdest4, tlast4} !== {q4[0].data, q4[0].dest, q4[0].tail}) begin
          tests_failed++;
          $display("FAIL rand_head c%0d: got %h/%h/%h/%b want %h/%h/%b", c,
                   tdata4, tid4, tdest4, tlast4, q4[0].data, q4[0].dest, q4[0].tail);
        end
      end
      tests_run++;
      if (credit4 !== exp_credit4 || ovf4 !== exp_ovf4 || pkt4 !== exp_pkt4) begin
        tests_failed++;
        $display("FAIL rand_status c%0d: got credit=%b ovf=%b pkt=%0d want %b/%b/%0d", c,
                 credit4, ovf4, pkt4, exp_credit4, exp_ovf4, exp_pkt4);
      end
      drive4(rand_flit($urandom_range(0, 3) == 0), $urandom_range(0, 9) < 6);
      tready4 = ($urandom_range(0, 9) < 5);
      advance();
    end
  endtask

  task automatic test_reset_mid();
    int credits = 0;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive4(rand_flit(1'b1), 1'b1);
      advance();
    end
    send4 = 1'b0;
    tests_run++;
    if (occ4 !== 3'd3) begin
      tests_failed++;
      $display("FAIL rstmid_preload: got occ=%0d want 3", occ4);
    end
    #2;
    rst_n = 1'b0;
    #1;
    clear_model();
    tests_run++;
    if (tvalid4 !== 1'b0 || occ4 !== 3'd0) begin
      tests_failed++;
      $display("FAIL rstmid_async: got tvalid=%b occ=%0d want 0/0", tvalid4, occ4);
    end
    tready4 = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
      credits += int'(credit4);
    end
    rst_n = 1'b1;
    repeat (2) begin
      advance();
      credits += int'(credit4);
    end
    tests_run++;
    if (credits != 0 || pkt4 !== 16'd0 || tvalid4 !== 1'b0) begin
      tests_failed++;
      $display("FAIL rstmid_after: got credits=%0d pkt=%0d tvalid=%b want 0/0/0", credits, pkt4, tvalid4);
    end
  endtask

  task automatic test_pkt_wrap();
    do_reset();
    tready4 = 1'b1;
    for (int i = 0; i < 65536; i++) begin
      drive4(rand_flit(1'b1), 1'b1);
      advance();
    end
    send4 = 1'b0;
    tests_run++;
    if (pkt4 !== 16'hFFFF || pkt4 !== exp_pkt4) begin
      tests_failed++;
      $display("FAIL pkt_max: got %h want ffff (model %h)", pkt4, exp_pkt4);
    end
    advance();
    tests_run++;
    if (pkt4 !== 16'h0000 || pkt4 !== exp_pkt4) begin
      tests_failed++;
      $display("FAIL pkt_wrap: got %h want 0000 (model %h)", pkt4, exp_pkt4);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_full_pushpop();
    test_wrap3();
    test_random();
    test_reset_mid();
    test_pkt_wrap();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/noc_link_rx.md
NOC_LINK_RX -- requirements
Module: noc_link_rx

Interface
REQ-001 SHALL have parameter FLIT_WIDTH, default 128, flit payload width.
REQ-002 SHALL have parameter TID_WIDTH, default 2, ID field width within dest.
REQ-003 SHALL have parameter TDEST_WIDTH, default 4, destination field width within dest.
REQ-004 SHALL have parameter DEST_WIDTH, default TID_WIDTH+TDEST_WIDTH, link dest width.
REQ-005 SHALL have parameter FLIT_BUFFER_DEPTH, default 4 (legal range 1..64), receive buffer slots; equals the sender's initial credit count.
REQ-006 SHALL have clk_noc, input, 1, sole clock; one clock, all logic rising-edge.
REQ-007 SHALL have rst_n, input, 1, reset, asynchronous and active-low.
REQ-008 SHALL have data_in, input, FLIT_WIDTH, flit payload from the upstream router output.
REQ-009 SHALL have dest_in, input, DEST_WIDTH, flit destination {tid, tdest}.
REQ-010 SHALL have is_tail_in, input, 1, last flit of packet.
REQ-011 SHALL have send_in, input, 1, flit valid this cycle (no backpressure).
REQ-012 SHALL have credit_out, output, 1, one-cycle pulse returning one buffer slot.
REQ-013 SHALL have axis_out_tvalid/tready/tdata/tlast/tid/tdest, AXI-Stream master, widths 1/1/FLIT_WIDTH/1/TID_WIDTH/TDEST_WIDTH.
REQ-014 SHALL have occupancy, output, clog2(FLIT_BUFFER_DEPTH+1), buffered flit count.
REQ-015 SHALL have overflow_err, output, 1, sticky protocol-violation flag.
REQ-016 SHALL have pkt_count, output, 16, packets delivered (tail flits popped), wraps.

Function
REQ-017 SHALL write {data_in, dest_in, is_tail_in} into a circular FIFO on any cycle send_in=1 and the FIFO is not full, or it is full and a pop occurs in the same cycle.
REQ-018 SHALL, when send_in=1 with FIFO full and no same-cycle pop, drop the flit, leave FIFO contents unchanged, and set overflow_err=1 from the next cycle until reset.
REQ-019 SHALL present the head entry on axis_out_* with axis_out_tvalid=1 whenever occupancy>0; a flit written in cycle N SHALL be visible no earlier than cycle N+1.
REQ-020 SHALL pop the head when axis_out_tvalid&axis_out_tready; tdata/tlast/tid/tdest SHALL remain stable while tvalid=1 and tready=0.
REQ-021 SHALL map tid=dest[DEST_WIDTH-1:TDEST_WIDTH], tdest=dest[TDEST_WIDTH-1:0], tlast=is_tail.
REQ-022 SHALL register credit_out: a pop in cycle N yields credit_out=1 in cycle N+1 only; back-to-back pops yield back-to-back pulses; dropped flits return no credit.
REQ-023 SHALL update occupancy as +1 push, -1 pop, unchanged on simultaneous push and pop (including at full and at one-entry).
REQ-024 SHALL wrap read/write pointers modulo FLIT_BUFFER_DEPTH, including non-power-of-two depths.
REQ-025 SHALL increment pkt_count by 1 on each pop with tlast=1, wrapping 0xFFFF->0x0000.
REQ-026 SHALL not reorder flits; output order equals accepted input order.

Reset
REQ-027 SHALL, while rst_n=0, force axis_out_tvalid=0, credit_out=0, occupancy=0, overflow_err=0, pkt_count=0, pointers=0, immediately (asynchronous assertion).
REQ-028 SHALL discard all buffered flits on reset mid-operation and issue no credits for them; the upstream sender is reset in the same domain and restarts with FLIT_BUFFER_DEPTH credits.
REQ-029 SHALL leave FIFO storage array unreset (data only).

Structure
REQ-030 SHALL take flit/dest field widths and a packed flit struct {data, dest, is_tail} from the shared NoC package; no local redefinition.
REQ-031 SHALL contain one sub-module, noc_link_rx_fifo (storage + pointers + count); credit, error and packet logic in the top.

Verification
REQ-032 Reset then 4 sends (dest=0x2B, last is_tail=1), tready=1 -> 4 flits out with tid=2'b10, tdest=4'hB, 4 credit pulses each 1 cycle after pop, pkt_count=1.
REQ-033 tready=0, 4 sends -> occupancy=4, tvalid held, data stable, no credits; 5th send -> overflow_err=1, occupancy stays 4, drained output equals first 4 flits only.
REQ-034 FIFO full, send_in and tready both 1 same cycle -> flit accepted, occupancy stays 4, overflow_err stays 0, one credit next cycle.
REQ-035 FLIT_BUFFER_DEPTH=3, 10 streamed flits with random tready -> in-order delivery across pointer wrap, total credits=10.
REQ-036 rst_n low with occupancy=3 -> tvalid=0 and occupancy=0 same cycle, zero credits emitted, pkt_count=0.
REQ-037 pkt_count preset by 65536 single-flit packets -> value returns to 0x0000.
